// File: rtl/branch_target_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_target_predictor_if
//  Brief    : Lookup / update / statistics bundle between the pipeline and
//             the branch target predictor. The pipeline side is the master.
//  Revision : 1.0  initial release
// ============================================================================
interface branch_target_predictor_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int STAT_WIDTH = 16
);
  // Whole-table invalidate
  logic                  flush;
  // IF-stage lookup
  logic [ADDR_WIDTH-1:0] lk_pc;
  logic                  lk_hit;
  logic                  lk_taken;
  logic [ADDR_WIDTH-1:0] lk_next_pc;
  // ID-stage resolution
  logic                  upd_valid;
  logic [ADDR_WIDTH-1:0] upd_pc;
  logic                  upd_taken;
  logic [ADDR_WIDTH-1:0] upd_target;
  logic                  upd_pred_taken;
  logic [ADDR_WIDTH-1:0] upd_pred_target;
  logic                  upd_mispredict;
  // Statistics
  logic [STAT_WIDTH-1:0] stat_branches;
  logic [STAT_WIDTH-1:0] stat_mispredicts;

  modport master (
    output flush, lk_pc,
    output upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    input  lk_hit, lk_taken, lk_next_pc, upd_mispredict,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  flush, lk_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    output lk_hit, lk_taken, lk_next_pc, upd_mispredict,
    output stat_branches, stat_mispredicts
  );
endinterface
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : branch_target_predictor
//  Brief    : Direct-mapped branch target buffer with per-entry saturating
//             direction counters. Lookup is combinational for the IF stage;
//             the ID stage trains the table and the statistics counters.
//  Revision : 1.0  initial release
// ============================================================================
module branch_target_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 8,
  parameter int CTR_BITS   = 2,
  parameter int STAT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,   // asynchronous, active low
  branch_target_predictor_if.slave   bus
);

  localparam int ENTRIES = 2 ** INDEX_BITS;

  // Counter encodings: saturate high, allocate as weakly taken, reset/flush
  // as weakly not taken (MSB of the counter is the taken prediction).
  localparam logic [CTR_BITS-1:0]   c_ctr_max   = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]   c_ctr_min   = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0]   c_ctr_alloc = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0]   c_ctr_init  = c_ctr_alloc - CTR_BITS'(1);
  localparam logic [ADDR_WIDTH-1:0] c_pc_step   = ADDR_WIDTH'(4);
  localparam logic [STAT_WIDTH-1:0] c_stat_max  = {STAT_WIDTH{1'b1}};

  // Table storage, one slot per index
  logic [ENTRIES-1:0]    r_valid;
  logic [TAG_BITS-1:0]   r_tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
  logic [CTR_BITS-1:0]   r_ctr    [ENTRIES];

  // Statistics
  logic [STAT_WIDTH-1:0] r_stat_branches;
  logic [STAT_WIDTH-1:0] r_stat_mispredicts;

  // Lookup side decode
  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_BITS-1:0]   w_lk_tag;
  logic                  w_lk_hit;
  logic                  w_lk_taken;

  // Update side decode
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [TAG_BITS-1:0]   w_upd_tag;
  logic                  w_upd_hit;
  logic [CTR_BITS-1:0]   w_upd_ctr;
  logic [CTR_BITS-1:0]   w_ctr_inc;
  logic [CTR_BITS-1:0]   w_ctr_dec;
  logic                  w_mispredict;

  // PC bits outside index/tag (byte offset and high bits) never take part
  // in indexing or tag matching; aliasing across them is intentional.
  logic                  w_unused_upd_pc_bits;

  assign w_lk_idx  = bus.lk_pc[INDEX_BITS+1:2];
  assign w_lk_tag  = bus.lk_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign w_upd_idx = bus.upd_pc[INDEX_BITS+1:2];
  assign w_upd_tag = bus.upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign w_unused_upd_pc_bits = ^bus.upd_pc;

  // Lookup reads the pre-edge table contents; no bypass from the update port.
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][CTR_BITS-1];

  assign bus.lk_hit     = w_lk_hit;
  assign bus.lk_taken   = w_lk_taken;
  assign bus.lk_next_pc = w_lk_taken ? r_target[w_lk_idx] : (bus.lk_pc + c_pc_step);

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
  assign w_upd_ctr = r_ctr[w_upd_idx];
  assign w_ctr_inc = (w_upd_ctr == c_ctr_max) ? w_upd_ctr : (w_upd_ctr + CTR_BITS'(1));
  assign w_ctr_dec = (w_upd_ctr == c_ctr_min) ? w_upd_ctr : (w_upd_ctr - CTR_BITS'(1));

  // A branch is mispredicted if the direction was wrong, or if it was taken
  // and the carried-down target does not match the real one.
  assign w_mispredict = bus.upd_valid &&
                        ((bus.upd_pred_taken != bus.upd_taken) ||
                         (bus.upd_taken && (bus.upd_pred_target != bus.upd_target)));

  assign bus.upd_mispredict   = w_mispredict;
  assign bus.stat_branches    = r_stat_branches;
  assign bus.stat_mispredicts = r_stat_mispredicts;

  // Table training: flush wins over an update on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= c_ctr_init;
      end
    end else if (bus.flush) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= c_ctr_init;
      end
    end else if (bus.upd_valid) begin
      if (w_upd_hit) begin
        if (bus.upd_taken) begin
          r_ctr[w_upd_idx]    <= w_ctr_inc;
          r_target[w_upd_idx] <= bus.upd_target;
        end else begin
          r_ctr[w_upd_idx]    <= w_ctr_dec;
        end
      end else if (bus.upd_taken) begin
        // Allocate, replacing whatever alias occupied the slot.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= bus.upd_target;
        r_ctr[w_upd_idx]    <= c_ctr_alloc;
      end
    end
  end

  // Saturating statistics; counted on every resolved branch, even under flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (bus.upd_valid) begin
      if (r_stat_branches != c_stat_max) begin
        r_stat_branches <= r_stat_branches + STAT_WIDTH'(1);
      end
      if (w_mispredict && (r_stat_mispredicts != c_stat_max)) begin
        r_stat_mispredicts <= r_stat_mispredicts + STAT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_target_predictor
//  Brief    : Directed and random stimulus for branch_target_predictor against
//             an arithmetic reference model. Two instances share stimulus; the
//             second uses 4-bit statistics counters to reach saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_target_predictor;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] lk_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  int n_checks;
  int n_errors;

  // Reference model: 16 slots, counters as plain integers 0..3
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  int unsigned m_target [16];
  int          m_ctr    [16];
  int          m_br;
  int          m_mp;

  branch_target_predictor_if #(.ADDR_WIDTH(32), .STAT_WIDTH(16)) bus   ();
  branch_target_predictor_if #(.ADDR_WIDTH(32), .STAT_WIDTH(4))  bus_s ();

  assign bus.flush             = flush;
  assign bus.lk_pc             = lk_pc;
  assign bus.upd_valid         = upd_valid;
  assign bus.upd_pc            = upd_pc;
  assign bus.upd_taken         = upd_taken;
  assign bus.upd_target        = upd_target;
  assign bus.upd_pred_taken    = upd_pred_taken;
  assign bus.upd_pred_target   = upd_pred_target;
  assign bus_s.flush           = flush;
  assign bus_s.lk_pc           = lk_pc;
  assign bus_s.upd_valid       = upd_valid;
  assign bus_s.upd_pc          = upd_pc;
  assign bus_s.upd_taken       = upd_taken;
  assign bus_s.upd_target      = upd_target;
  assign bus_s.upd_pred_taken  = upd_pred_taken;
  assign bus_s.upd_pred_target = upd_pred_target;

  branch_target_predictor #(
    .ADDR_WIDTH(32), .INDEX_BITS(4), .TAG_BITS(8), .CTR_BITS(2), .STAT_WIDTH(16)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  branch_target_predictor #(
    .ADDR_WIDTH(32), .INDEX_BITS(4), .TAG_BITS(8), .CTR_BITS(2), .STAT_WIDTH(4)
  ) u_dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model helpers ----------------
  function automatic int idx_of(input logic [31:0] pc);
    int unsigned p = pc;
    return int'((p / 4) % 16);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    int unsigned p = pc;
    return (p / 64) % 256;
  endfunction

  function automatic bit exp_hit(input logic [31:0] pc);
    return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
  endfunction

  function automatic bit exp_taken(input logic [31:0] pc);
    return exp_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
  endfunction

  function automatic logic [31:0] exp_next(input logic [31:0] pc);
    int unsigned p = pc;
    return exp_taken(pc) ? m_target[idx_of(pc)] : p + 32'd4;
  endfunction

  function automatic bit exp_mis();
    return upd_valid && ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));
  endfunction

  function automatic logic [31:0] sat(input int n, input int w);
    int lim = (1 << w) - 1;
    return (n > lim) ? 32'(lim) : 32'(n);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      m_valid[k] = 1'b0; m_tag[k] = 0; m_target[k] = 0; m_ctr[k] = 1;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  // Applies the effect of one rising edge given the inputs held across it.
  task automatic model_edge();
    int i;
    if (!reset) begin
      model_reset();
      return;
    end
    if (upd_valid) begin
      m_br++;
      if (exp_mis()) m_mp++;
    end
    if (flush) begin
      for (int k = 0; k < 16; k++) begin
        m_valid[k] = 1'b0; m_ctr[k] = 1;
      end
    end else if (upd_valid) begin
      i = idx_of(upd_pc);
      if (exp_hit(upd_pc)) begin
        if (upd_taken) begin
          m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_target[i] = upd_target;
        end else begin
          m_ctr[i]    = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(upd_pc);
        m_target[i] = upd_target;
        m_ctr[i]    = 2;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, "_hit"},   32'(bus.lk_hit),           32'(exp_hit(lk_pc)));
    check({ph, "_taken"}, 32'(bus.lk_taken),         32'(exp_taken(lk_pc)));
    check({ph, "_next"},  bus.lk_next_pc,            exp_next(lk_pc));
    check({ph, "_mis"},   32'(bus.upd_mispredict),   32'(exp_mis()));
    check({ph, "_br"},    32'(bus.stat_branches),    sat(m_br, 16));
    check({ph, "_mp"},    32'(bus.stat_mispredicts), sat(m_mp, 16));
    check({ph, "_s_nxt"}, bus_s.lk_next_pc,          exp_next(lk_pc));
    check({ph, "_s_br"},  32'(bus_s.stat_branches),  sat(m_br, 4));
    check({ph, "_s_mp"},  32'(bus_s.stat_mispredicts), sat(m_mp, 4));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // One update (optionally with flush): checks before and after the edge.
  task automatic apply(input string ph, input logic [31:0] pc, input bit tk,
                       input logic [31:0] tgt, input bit ptk,
                       input logic [31:0] ptgt, input bit fl);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_pred_taken = ptk; upd_pred_target = ptgt; flush = fl;
    #1;
    check_all({ph, "_pre"});
    tick();
    upd_valid = 1'b0; flush = 1'b0;
    #1;
    check_all({ph, "_post"});
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [7:0] tags [4];
    int unsigned p;
    tags[0] = 8'h00; tags[1] = 8'h01; tags[2] = 8'h5A; tags[3] = 8'hFF;
    p = ($urandom & 32'hFFFF_C000) | (32'(tags[$urandom % 4]) << 6) |
        (($urandom % 16) << 2) | ($urandom % 4);
    return p;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit exp_t3 [8];
    logic [31:0] rp;
    n_checks = 0; n_errors = 0;
    reset = 1'b0; flush = 1'b0; lk_pc = '0; upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;

    // 1. Cold lookup
    lk_pc = 32'h0040_0010;
    #1;
    check("t1_hit",   32'(bus.lk_hit),           32'd0);
    check("t1_taken", 32'(bus.lk_taken),         32'd0);
    check("t1_next",  bus.lk_next_pc,            32'h0040_0014);
    check("t1_br",    32'(bus.stat_branches),    32'd0);
    check("t1_mp",    32'(bus.stat_mispredicts), 32'd0);
    check_all("t1");

    // 2. Allocate on a taken branch
    upd_valid = 1'b1; upd_pc = 32'h0040_0010; upd_taken = 1'b1;
    upd_target = 32'h0040_0000; upd_pred_taken = 1'b0; upd_pred_target = 32'h0040_0014;
    #1;
    check("t2_mis", 32'(bus.upd_mispredict), 32'd1);
    tick();
    upd_valid = 1'b0;
    #1;
    check("t2_hit",   32'(bus.lk_hit),           32'd1);
    check("t2_taken", 32'(bus.lk_taken),         32'd1);
    check("t2_next",  bus.lk_next_pc,            32'h0040_0000);
    check("t2_br",    32'(bus.stat_branches),    32'd1);
    check("t2_mp",    32'(bus.stat_mispredicts), 32'd1);

    // 3. Counter saturation: 3 not-taken then 4 taken, then one not-taken
    exp_t3 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      apply("t3", 32'h0040_0010, (k >= 3 && k < 7), 32'h0040_0000,
            exp_taken(32'h0040_0010), exp_next(32'h0040_0010), 1'b0);
      check($sformatf("t3_taken_%0d", k), 32'(bus.lk_taken), 32'(exp_t3[k]));
    end

    // 4. Alias replacement at index 4
    lk_pc = 32'h0040_0050;
    #1;
    check("t4_alias_miss", 32'(bus.lk_hit), 32'd0);
    apply("t4", 32'h0040_0050, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0054, 1'b0);
    check("t4_new_hit",  32'(bus.lk_hit),  32'd1);
    check("t4_new_next", bus.lk_next_pc,   32'h0040_0100);
    lk_pc = 32'h0040_0010;
    #1;
    check("t4_old_miss", 32'(bus.lk_hit), 32'd0);
    check_all("t4_old");

    // 5. flush together with a taken update
    apply("t5a", 32'h0040_0090, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0094, 1'b0);
    rp = 32'(bus.stat_branches);
    apply("t5", 32'h0040_00D0, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_00D4, 1'b1);
    check("t5_br_inc", 32'(bus.stat_branches), rp + 32'd1);
    for (int k = 0; k < 4; k++) begin
      lk_pc = 32'h0040_0010 + 32'(k * 64);
      #1;
      check($sformatf("t5_miss_%0d", k), 32'(bus.lk_hit), 32'd0);
    end

    // PC+4 wraps at the top of the address space
    lk_pc = 32'hFFFF_FFFC;
    #1;
    check("wrap_next", bus.lk_next_pc, 32'h0000_0000);

    // 6. Stat saturation on the 4-bit instance, then asynchronous reset
    lk_pc = 32'h0040_0010;
    for (int k = 0; k < 20; k++) begin
      apply("t6", 32'h0040_0010, 1'b1, 32'h0040_0400 + 32'(k * 4),
            1'b0, 32'h0040_0014, 1'b0);
    end
    check("t6_s_mp_sat", 32'(bus_s.stat_mispredicts), 32'd15);
    check("t6_hit_pre",  32'(bus.lk_hit),              32'd1);
    upd_valid = 1'b1; upd_pc = 32'h0040_0050; upd_taken = 1'b1;
    upd_target = 32'h0040_0500; upd_pred_taken = 1'b0;
    #1 reset = 1'b0;
    model_reset();
    #1;
    check("t6_rst_br",   32'(bus.stat_branches),      32'd0);
    check("t6_rst_mp",   32'(bus.stat_mispredicts),   32'd0);
    check("t6_rst_sbr",  32'(bus_s.stat_branches),    32'd0);
    check("t6_rst_smp",  32'(bus_s.stat_mispredicts), 32'd0);
    check("t6_rst_hit",  32'(bus.lk_hit),             32'd0);
    check("t6_rst_tk",   32'(bus.lk_taken),           32'd0);
    check("t6_rst_next", bus.lk_next_pc,              32'h0040_0014);
    tick();
    check("t6_drop_br",  32'(bus.stat_branches),      32'd0);
    lk_pc = 32'h0040_0050;
    #1;
    check("t6_drop_hit", 32'(bus.lk_hit),             32'd0);
    upd_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_all("t6_rel");

    // Random traffic over a small tag pool so hits, aliases and counters churn
    for (int n = 0; n < 400; n++) begin
      lk_pc     = rnd_pc();
      upd_valid = ($urandom % 4) != 0;
      upd_pc    = (($urandom % 4) == 0) ? lk_pc : rnd_pc();
      upd_taken = $urandom % 2;
      upd_target = (($urandom % 2) != 0) ? m_target[idx_of(upd_pc)] : ($urandom & 32'hFFFF_FFFC);
      if (($urandom % 4) != 0) begin
        upd_pred_taken  = exp_taken(upd_pc);
        upd_pred_target = exp_next(upd_pc);
      end else begin
        upd_pred_taken  = $urandom % 2;
        upd_pred_target = $urandom;
      end
      flush = ($urandom % 40) == 0;
      #1;
      check_all("rnd");
      tick();
    end
    upd_valid = 1'b0; flush = 1'b0;
    #1;
    check_all("end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
